// File: rtl/keypad_pkg.sv
// Shared constants, key map and scan-state type for the CHIP-8 hex keypad scanner.
// The matrix is 4 rows by 4 columns; KEYMAP turns a (row, col) contact into a CHIP-8 key value.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Rows top to bottom: 1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F
    localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

    typedef enum logic [1:0] {
        DRIVE,
        SAMPLE,
        UPDATE
    } scan_state_t;

    function automatic logic [3:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic int unsigned count_ones(input logic [NUM_KEYS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus CPU-facing key state and FX0A wait handshake.
// The slave modport is the scanner; the master modport is the pins/CPU side.
interface keypad_scanner_if;

    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys;
    logic        wait_req;
    logic        wait_ack;
    logic [3:0]  wait_key;

    modport master (
        output row_n,
        output wait_req,
        input  col_n,
        input  keys,
        input  wait_ack,
        input  wait_key
    );

    modport slave (
        input  row_n,
        input  wait_req,
        output col_n,
        output keys,
        output wait_ack,
        output wait_key
    );

endinterface

// File: rtl/key_filter.sv
// Per-key scan filter: the key flips only after STABLE_SCANS consecutive disagreeing scans.
// Counter and state move only on the scan's update strobe.
module key_filter #(
    parameter int unsigned STABLE_SCANS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic update,
    input  logic raw,
    output logic key
);

    localparam int unsigned CntW = $clog2(STABLE_SCANS + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_q, key_d;

    always_comb begin
        cnt_d = cnt_q;
        key_d = key_q;
        if (update) begin
            if (raw == key_q) begin
                cnt_d = '0;
            end else if (32'(cnt_q) + 32'd1 == STABLE_SCANS) begin
                key_d = ~key_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            key_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            key_q <= key_d;
        end
    end

    assign key = key_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning CHIP-8 keypad controller with per-key filtering and FX0A wait handshake.
// Define KEYPAD_GHOST_REJECT_EN to discard scans whose raw image shows three or more keys.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned STABLE_SCANS  = 8
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.slave  kp_io
);

    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

    scan_state_t         state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic [NUM_KEYS-1:0] raw_q, raw_d;
    logic [3:0]          row_meta_q, row_sync_q;
    logic [3:0]          col_drive;

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] keys_dly_q;
    logic [NUM_KEYS-1:0] press;
    logic                ghost;
    logic                filt_update;
    logic                ack_arm_q, ack_arm_d;
    logic                wait_ack;
    logic [3:0]          wait_key_q, wait_key;

    // row_n is asynchronous to clk; only row_sync_q is ever sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp_io.row_n;
            row_sync_q <= row_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        settle_d  = settle_q;
        raw_d     = raw_q;
        col_drive = 4'hF;
        unique case (state_q)
            DRIVE: begin
                col_drive = ~(4'b0001 << col_q);
                if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            SAMPLE: begin
                col_drive = ~(4'b0001 << col_q);
                for (int r = 0; r < NUM_ROWS; r++) begin
                    raw_d[KEYMAP[2'(r)][col_q]] = ~row_sync_q[2'(r)];
                end
                if (col_q == 2'd3) begin
                    state_d = UPDATE;
                end else begin
                    col_d   = col_q + 2'd1;
                    state_d = DRIVE;
                end
            end
            UPDATE: begin
                col_d   = '0;
                state_d = DRIVE;
            end
            default: begin
                col_d    = '0;
                settle_d = '0;
                state_d  = DRIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DRIVE;
            col_q    <= '0;
            settle_q <= '0;
            raw_q    <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            settle_q <= settle_d;
            raw_q    <= raw_d;
        end
    end

    // Columns float high for as long as reset is held, not just from the next edge.
    assign kp_io.col_n = reset ? 4'hF : col_drive;

`ifdef KEYPAD_GHOST_REJECT_EN
    assign ghost = count_ones(raw_q) >= 3;
`else
    assign ghost = 1'b0;
`endif

    assign filt_update = (state_q == UPDATE) && !ghost;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_filter
        key_filter #(
            .STABLE_SCANS (STABLE_SCANS)
        ) u_filter (
            .clk    (clk),
            .reset  (reset),
            .update (filt_update),
            .raw    (raw_q[k]),
            .key    (keys[k])
        );
    end

    // keys_dly_q holds the pre-UPDATE image in the cycle keys first shows the filter result,
    // so press is exactly the new rising edges, aligned with keys.
    assign ack_arm_d = (state_q == UPDATE) && kp_io.wait_req;
    assign press     = keys & ~keys_dly_q;
    assign wait_ack  = ack_arm_q && (press != '0);
    assign wait_key  = wait_ack ? lowest_set(press) : wait_key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_dly_q <= '0;
            ack_arm_q  <= 1'b0;
            wait_key_q <= '0;
        end else begin
            keys_dly_q <= keys;
            ack_arm_q  <= ack_arm_d;
            wait_key_q <= wait_key;
        end
    end

    assign kp_io.keys     = keys;
    assign kp_io.wait_ack = wait_ack;
    assign kp_io.wait_key = wait_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives row_n from col_n, and a scan-level
// reference model predicts col_n, keys and the wait handshake on every cycle.
module tb_keypad_scanner;

    localparam int SETTLE = 4;
    localparam int STABLE = 3;
    localparam int PERIOD = 4 * (SETTLE + 1) + 1;

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .STABLE_SCANS  (STABLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp_io (kp)
    );

    // Physical keypad: bit k set means CHIP-8 key k is held down.
    logic [15:0] pressed = '0;

    function automatic logic [3:0] key_at(input int r, input int c);
        case (r * 4 + c)
            0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hC;
            4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hD;
            8: return 4'h7;   9: return 4'h8;   10: return 4'h9;  11: return 4'hE;
            12: return 4'hA;  13: return 4'h0;  14: return 4'hB;  default: return 4'hF;
        endcase
    endfunction

    always_comb begin
        kp.row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.col_n[c] && pressed[key_at(r, c)]) begin
                    kp.row_n[r] = 1'b0;
                end
            end
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          phase = 0;
    int          m_cnt [16];
    logic [15:0] m_keys = '0;
    logic        m_ack = 1'b0;
    logic [3:0]  m_wkey = '0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t, phase %0d)", name, got, exp, $time,
                     phase);
        end
    endtask

    // One scan's worth of filtering, applied to the key set that was held during that scan.
    task automatic model_update();
        logic [15:0] nxt;
        logic [15:0] press;
        nxt = m_keys;
        if (!(GHOST && $countones(pressed) >= 3)) begin
            for (int k = 0; k < 16; k++) begin
                if (pressed[k] == m_keys[k]) begin
                    m_cnt[k] = 0;
                end else if (m_cnt[k] + 1 == STABLE) begin
                    nxt[k]   = ~nxt[k];
                    m_cnt[k] = 0;
                end else begin
                    m_cnt[k]++;
                end
            end
        end
        press  = nxt & ~m_keys;
        m_keys = nxt;
        if (kp.wait_req && press != '0) begin
            m_ack = 1'b1;
            for (int k = 15; k >= 0; k--) begin
                if (press[k]) m_wkey = k[3:0];
            end
        end
    endtask

    // Single compare point: every negedge, DUT outputs against the model.
    task automatic tick();
        logic [3:0] exp_col;
        @(negedge clk);
        if (reset) begin
            phase  = 0;
            m_keys = '0;
            m_ack  = 1'b0;
            m_wkey = '0;
            for (int k = 0; k < 16; k++) m_cnt[k] = 0;
            chk("reset col_n", 16'(kp.col_n), 16'hF);
            chk("reset keys", kp.keys, 16'h0);
            chk("reset wait_ack", 16'(kp.wait_ack), 16'h0);
            chk("reset wait_key", 16'(kp.wait_key), 16'h0);
        end else begin
            phase = (phase + 1) % PERIOD;
            if (phase == PERIOD - 1) exp_col = 4'hF;
            else                     exp_col = ~(4'b0001 << (phase / (SETTLE + 1)));
            chk("col_n", 16'(kp.col_n), 16'(exp_col));
            chk("keys", kp.keys, m_keys);
            chk("wait_ack", 16'(kp.wait_ack), 16'(m_ack));
            chk("wait_key", 16'(kp.wait_key), 16'(m_wkey));
            if (phase == 0) m_ack = 1'b0;
            if (phase == PERIOD - 1) model_update();
        end
    endtask

    // Advance to just after the check of the first cycle following an UPDATE.
    task automatic run_scan();
        do tick(); while (phase != 0);
    endtask

    task automatic run_scans(input int n);
        for (int i = 0; i < n; i++) run_scan();
    endtask

    initial begin
        kp.wait_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Key 6 (row1/col2) held; reset lands in col 2's DRIVE window.
        pressed[6] = 1'b1;
        repeat (11) tick();
        chk("col2 driven before reset", 16'(kp.col_n), 16'hB);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("first drive after reset", 16'(kp.col_n), 16'hE);

        run_scans(2);
        chk("key6 after 2 scans", kp.keys, 16'h0000);
        run_scan();
        chk("key6 after 3 scans", kp.keys, 16'h0040);
        pressed = '0;
        run_scans(2);
        chk("key6 release 2 scans", kp.keys, 16'h0040);
        run_scan();
        chk("key6 release 3 scans", kp.keys, 16'h0000);

        // FX0A: key A alone.
        kp.wait_req = 1'b1;
        pressed[10] = 1'b1;
        run_scans(3);
        chk("ack key A", 16'(kp.wait_ack), 16'h1);
        chk("wait_key A", 16'(kp.wait_key), 16'hA);
        run_scan();
        chk("no second ack", 16'(kp.wait_ack), 16'h0);
        chk("wait_key holds", 16'(kp.wait_key), 16'hA);
        pressed = '0;
        kp.wait_req = 1'b0;
        run_scans(3);

        // FX0A: 5 and 9 together give one ack naming 5.
        kp.wait_req = 1'b1;
        pressed[5] = 1'b1;
        pressed[9] = 1'b1;
        run_scans(3);
        chk("ack 5+9", 16'(kp.wait_ack), 16'h1);
        chk("wait_key 5", 16'(kp.wait_key), 16'h5);
        pressed = '0;
        kp.wait_req = 1'b0;
        run_scans(3);

        // Key 1 already down when wait_req rises: only the later key 2 acknowledges.
        pressed[1] = 1'b1;
        run_scans(3);
        chk("key1 held", kp.keys, 16'h0002);
        kp.wait_req = 1'b1;
        run_scans(3);
        chk("held key no ack", 16'(kp.wait_ack), 16'h0);
        pressed[2] = 1'b1;
        run_scans(3);
        chk("ack key 2", 16'(kp.wait_ack), 16'h1);
        chk("wait_key 2", 16'(kp.wait_key), 16'h2);
        pressed = '0;
        kp.wait_req = 1'b0;
        run_scans(3);

        // Bouncing key never settles.
        for (int i = 0; i < 10; i++) begin
            pressed[6] = ~pressed[6];
            run_scan();
        end
        chk("toggle keeps keys 0", kp.keys, 16'h0000);
        pressed = '0;
        run_scans(3);

        // Three keys at once.
        pressed = 16'h0016;
        run_scans(3);
        chk("three keys", kp.keys, GHOST ? 16'h0000 : 16'h0016);
        pressed = '0;
        run_scans(3);

        // Random traffic, including 3+ key images and a mid-run reset.
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 5))
                0, 1: pressed[$urandom_range(0, 15)] ^= 1'b1;
                2: begin
                    pressed[$urandom_range(0, 15)] ^= 1'b1;
                    pressed[$urandom_range(0, 15)] ^= 1'b1;
                end
                3: if ($countones(pressed) > 3) pressed = '0;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) kp.wait_req = ~kp.wait_req;
            if (s == 50) begin
                repeat ($urandom_range(1, PERIOD - 2)) tick();
                reset = 1'b1;
                repeat (2) tick();
                reset = 1'b0;
            end
            run_scan();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
